// File: rtl/router_pkt_pkg.sv
// rtl/router_pkt_pkg.sv - shared types, defaults and helpers for the router packet generator
package router_pkt_pkg;

    localparam int          DATA_W_DEF      = 8;
    localparam int          ADDR_W_DEF      = 2;
    localparam int          NUM_CH_DEF      = 3;
    localparam int          DRAIN_DELAY_DEF = 30;
    localparam logic [7:0]  LFSR_SEED_DEF   = 8'hA5;
    localparam logic [7:0]  LFSR_TAPS_DEF   = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_DRAIN_WAIT,
        ST_DRAIN,
        ST_GAP
    } gen_state_t;

    // Header byte is {len, addr}; callers truncate to their data width.
    function automatic logic [31:0] make_header(input logic [31:0] len,
                                                input logic [31:0] addr,
                                                input int          addr_w);
        return (len << addr_w) | addr;
    endfunction

    // One right-shifting Galois LFSR step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] val,
                                              input logic [31:0] taps);
        return val[0] ? ((val >> 1) ^ taps) : (val >> 1);
    endfunction

endpackage

// File: rtl/router_lfsr.sv
// rtl/router_lfsr.sv - Galois LFSR payload source with seed reload
module router_lfsr
    import router_pkt_pkg::*;
#(
    parameter int               WIDTH = DATA_W_DEF,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEF),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             advance_i,
    input  logic             load_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;

    // Reload the seed on reset or load, otherwise step when advanced.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            value_q <= SEED;
        end else if (load_i) begin
            value_q <= SEED;
        end else if (advance_i) begin
            value_q <= WIDTH'(lfsr_next(32'(value_q), 32'(TAPS)));
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/router_pkt_gen.sv
// rtl/router_pkt_gen.sv - router packet source/drain scheduler (optional ROUTER_PKT_GEN_ERR_INJECT_EN)
module router_pkt_gen
    import router_pkt_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                LEN_W       = DATA_W - ADDR_W,
    parameter int                NUM_CH      = NUM_CH_DEF,
    parameter logic [DATA_W-1:0] LFSR_SEED   = DATA_W'(LFSR_SEED_DEF),
    parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(LFSR_TAPS_DEF),
    parameter int                DRAIN_DELAY = DRAIN_DELAY_DEF
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [7:0]        cfg_pkt_num_i,
`ifdef ROUTER_PKT_GEN_ERR_INJECT_EN
    input  logic              inject_err_i,
`endif
    input  logic              busy_i,
    input  logic [NUM_CH-1:0] vld_out_i,
    output logic [DATA_W-1:0] data_in_o,
    output logic              pkt_valid_o,
    output logic [NUM_CH-1:0] read_enb_o,
    output logic              gen_busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic [7:0]        pkt_cnt_o
);

    gen_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]        pkt_num_q, pkt_num_d;
    logic [7:0]        pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       delay_q, delay_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [NUM_CH-1:0] read_enb_q, read_enb_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              gen_busy_q, gen_busy_d;
    logic [DATA_W-1:0] lfsr_val;
    logic              lfsr_adv;
    logic              lfsr_load;
    logic              addr_ok;
    logic [DATA_W-1:0] header;

`ifdef ROUTER_PKT_GEN_ERR_INJECT_EN
    logic              inject_q, inject_d;
`else
    logic              inject_q;
    assign inject_q = 1'b0;
`endif

    router_lfsr #(
        .WIDTH (DATA_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .advance_i (lfsr_adv),
        .load_i    (lfsr_load),
        .value_o   (lfsr_val)
    );

    assign addr_ok = 32'(cfg_addr_i) < 32'(NUM_CH);
    assign header  = DATA_W'(make_header(32'(len_q), 32'(addr_q), ADDR_W));

    // Next-state and registered-output computation; the byte stream states stall on busy.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        pkt_num_d   = pkt_num_q;
        pkt_cnt_d   = pkt_cnt_q;
        delay_d     = delay_q;
        parity_d    = parity_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        read_enb_d  = read_enb_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        lfsr_adv    = 1'b0;
        lfsr_load   = 1'b0;
`ifdef ROUTER_PKT_GEN_ERR_INJECT_EN
        inject_d    = inject_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (addr_ok) begin
                        addr_d    = cfg_addr_i;
                        len_d     = cfg_len_i;
                        pkt_num_d = (cfg_pkt_num_i == 8'd0) ? 8'd1 : cfg_pkt_num_i;
                        pkt_cnt_d = 8'd0;
                        cfg_err_d = 1'b0;
                        lfsr_load = 1'b1;
`ifdef ROUTER_PKT_GEN_ERR_INJECT_EN
                        inject_d  = inject_err_i;
`endif
                        state_d   = ST_HEADER;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                if (!busy_i) begin
                    data_d      = header;
                    pkt_valid_d = 1'b1;
                    parity_d    = header;
                    byte_cnt_d  = '0;
                    state_d     = (len_q == '0) ? ST_PARITY : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!busy_i) begin
                    data_d     = lfsr_val;
                    parity_d   = parity_q ^ lfsr_val;
                    lfsr_adv   = 1'b1;
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    if (byte_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy_i) begin
                    data_d      = inject_q ? ~parity_q : parity_q;
                    pkt_valid_d = 1'b0;
                    delay_d     = 16'(DRAIN_DELAY);
                    state_d     = ST_DRAIN_WAIT;
                end
            end
            ST_DRAIN_WAIT: begin
                // Counter holds DRAIN_DELAY..1 so read_enb rises DRAIN_DELAY edges after parity.
                if (delay_q <= 16'd1) begin
                    read_enb_d = NUM_CH'(1) << addr_q;
                    state_d    = ST_DRAIN;
                end else begin
                    delay_d = delay_q - 16'd1;
                end
            end
            ST_DRAIN: begin
                if (!vld_out_i[addr_q]) begin
                    read_enb_d = '0;
                    pkt_cnt_d  = pkt_cnt_q + 8'd1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (pkt_cnt_q == pkt_num_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gen_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears the packet in flight immediately.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            pkt_num_q   <= 8'd0;
            pkt_cnt_q   <= 8'd0;
            delay_q     <= 16'd0;
            parity_q    <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            read_enb_q  <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            gen_busy_q  <= 1'b0;
`ifdef ROUTER_PKT_GEN_ERR_INJECT_EN
            inject_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            pkt_num_q   <= pkt_num_d;
            pkt_cnt_q   <= pkt_cnt_d;
            delay_q     <= delay_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            read_enb_q  <= read_enb_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            gen_busy_q  <= gen_busy_d;
`ifdef ROUTER_PKT_GEN_ERR_INJECT_EN
            inject_q    <= inject_d;
`endif
        end
    end

    assign data_in_o   = data_q;
    assign pkt_valid_o = pkt_valid_q;
    assign read_enb_o  = read_enb_q;
    assign gen_busy_o  = gen_busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
    assign pkt_cnt_o   = pkt_cnt_q;

endmodule
